// File: rtl/ccip_rd_arbiter.sv
// Round-robin arbiter sharing the CCI-P c0 read-request path between NUM_REQ requesters.
// Optional statistics counters are built only when RD_ARB_STATS_EN is defined.

module ccip_rd_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = 42,
    parameter int TAG_W     = 8,
    parameter int MAX_OUTST = 64
) (
    input  logic                      Clk_400,
    input  logic                      SoftReset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      c0tx_valid,
    output logic [ADDR_W-1:0]         c0tx_addr,
    output logic [15:0]               c0tx_mdata,
    input  logic                      c0TxAlmFull,
    input  logic                      c0rx_rdValid,
    input  logic [15:0]               c0rx_mdata,
    input  logic [511:0]              c0rx_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [TAG_W-1:0]          rsp_tag,
    output logic [511:0]              rsp_data,
    output logic [NUM_REQ*8-1:0]      outst_cnt,
    output logic [NUM_REQ*32-1:0]     stat_issued,
    output logic [31:0]               stat_stall
);

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] grant;
    logic [1:0]         grant_id;
    int                 scan_idx;
    logic [1:0]         last_grant_q;
    logic [7:0]         outst_q [NUM_REQ];
    logic [7:0]         outst_d [NUM_REQ];
    logic [NUM_REQ-1:0] uflow;

    logic               c0tx_valid_q;
    logic [ADDR_W-1:0]  c0tx_addr_q;
    logic [15:0]        c0tx_mdata_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [TAG_W-1:0]   rsp_tag_q;
    logic [511:0]       rsp_data_q;
    logic               err_underflow_q;

    logic [1:0]         rx_id;
    logic               rx_ok;
    logic               unused_mdata_hi;

    assign rx_id           = c0rx_mdata[TAG_W+1:TAG_W];
    assign rx_ok           = c0rx_rdValid && (int'(rx_id) < NUM_REQ);
    assign unused_mdata_hi = ^c0rx_mdata[15:TAG_W+2];

    // NOTE: every signal driven from always_comb gets a default before any branch so no latch is inferred.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid[i] && (outst_q[i] < 8'(MAX_OUTST));
        end
    end

    // Search upward from the requester after the last winner, wrapping once.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        scan_idx = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = (int'(last_grant_q) + k) % NUM_REQ;
            if (grant == '0 && elig[scan_idx]) begin
                grant[scan_idx] = 1'b1;
                grant_id        = 2'(scan_idx);
            end
        end
        if (c0TxAlmFull || SoftReset) begin
            grant = '0;
        end
    end

    // Issue and response on the same requester cancel; a zero count never wraps.
    always_comb begin
        uflow = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            outst_d[i] = outst_q[i];
            if (grant[i] && !(rx_ok && int'(rx_id) == i)) begin
                outst_d[i] = outst_q[i] + 8'd1;
            end else if (!grant[i] && rx_ok && int'(rx_id) == i) begin
                if (outst_q[i] == 8'd0) begin
                    uflow[i] = 1'b1;
                end else begin
                    outst_d[i] = outst_q[i] - 8'd1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk_400 or posedge SoftReset) begin
        if (SoftReset) begin
            last_grant_q    <= 2'(NUM_REQ - 1);
            c0tx_valid_q    <= 1'b0;
            c0tx_addr_q     <= '0;
            c0tx_mdata_q    <= '0;
            rsp_valid_q     <= '0;
            rsp_tag_q       <= '0;
            rsp_data_q      <= '0;
            err_underflow_q <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                outst_q[i] <= '0;
            end
        end else begin
            c0tx_valid_q <= |grant;
            if (|grant) begin
                last_grant_q <= grant_id;
                c0tx_addr_q  <= req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
                c0tx_mdata_q <= 16'({grant_id, req_tag[int'(grant_id)*TAG_W +: TAG_W]});
            end
            rsp_valid_q <= rx_ok ? (NUM_REQ'(1) << rx_id) : '0;
            if (rx_ok) begin
                rsp_tag_q  <= c0rx_mdata[TAG_W-1:0];
                rsp_data_q <= c0rx_data;
            end
            err_underflow_q <= err_underflow_q | (|uflow) | (c0rx_rdValid && !rx_ok);
            outst_q         <= outst_d;
        end
    end

    assign req_ready  = grant;
    assign c0tx_valid = c0tx_valid_q;
    assign c0tx_addr  = c0tx_addr_q;
    assign c0tx_mdata = c0tx_mdata_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_data   = rsp_data_q;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign outst_cnt[g*8 +: 8] = outst_q[g];
    end

`ifdef RD_ARB_STATS_EN
    logic [31:0] stat_issued_q [NUM_REQ];
    logic [31:0] stat_stall_q;

    always_ff @(posedge Clk_400 or posedge SoftReset) begin
        if (SoftReset) begin
            stat_stall_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_issued_q[i] <= '0;
            end
        end else begin
            if (c0TxAlmFull && (|req_valid)) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    stat_issued_q[i] <= stat_issued_q[i] + 32'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign stat_issued[g*32 +: 32] = stat_issued_q[g];
    end
    assign stat_stall = stat_stall_q;
`else
    assign stat_issued = '0;
    assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_ccip_rd_arbiter.sv
// Randomized self-checking bench for ccip_rd_arbiter against a transaction-level model
// (per-requester counts, round-robin pointer, queue of in-flight Mdata values).

module tb_ccip_rd_arbiter;

    localparam int N    = 2;
    localparam int AW   = 42;
    localparam int TW   = 8;
    localparam int MAXO = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*TW-1:0]   req_tag;
    logic [N-1:0]      req_ready;
    logic              c0tx_valid;
    logic [AW-1:0]     c0tx_addr;
    logic [15:0]       c0tx_mdata;
    logic              almfull;
    logic              rdvalid;
    logic [15:0]       rx_mdata;
    logic [511:0]      rx_data;
    logic [N-1:0]      rsp_valid;
    logic [TW-1:0]     rsp_tag;
    logic [511:0]      rsp_data;
    logic [N*8-1:0]    outst_cnt;
    logic [N*32-1:0]   stat_issued;
    logic [31:0]       stat_stall;

    ccip_rd_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .TAG_W(TW), .MAX_OUTST(MAXO)) dut (
        .Clk_400(clk), .SoftReset(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_tag(req_tag), .req_ready(req_ready),
        .c0tx_valid(c0tx_valid), .c0tx_addr(c0tx_addr), .c0tx_mdata(c0tx_mdata),
        .c0TxAlmFull(almfull), .c0rx_rdValid(rdvalid), .c0rx_mdata(rx_mdata), .c0rx_data(rx_data),
        .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
        .outst_cnt(outst_cnt), .stat_issued(stat_issued), .stat_stall(stat_stall)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int            m_outst [N];
    int            m_last;
    bit            m_err;
    logic          e_c0v;
    logic [AW-1:0] e_addr;
    logic [15:0]   e_mdata;
    logic [N-1:0]  e_rspv;
    logic [7:0]    e_tag;
    logic [511:0]  e_data;
    int            e_issued [N];
    int            e_stall;
    logic [15:0]   inflight [$];

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_outst[i]  = 0;
            e_issued[i] = 0;
        end
        m_last  = N - 1;
        m_err   = 1'b0;
        e_c0v   = 1'b0;
        e_addr  = '0;
        e_mdata = '0;
        e_rspv  = '0;
        e_tag   = '0;
        e_data  = '0;
        e_stall = 0;
        inflight.delete();
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        almfull   = 1'b0;
        rdvalid   = 1'b0;
        rx_mdata  = '0;
        rx_data   = '0;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [7:0] t);
        req_addr[i*AW +: AW] = a;
        req_tag[i*TW +: TW]  = t;
    endtask

    // Drive a response and retire the matching in-flight entry if the model knows it.
    task automatic drive_rsp(input logic [15:0] md);
        rdvalid  = 1'b1;
        rx_mdata = md;
        for (int w = 0; w < 16; w++) rx_data[w*32 +: 32] = $urandom;
        for (int k = 0; k < inflight.size(); k++) begin
            if (inflight[k] == md) begin
                inflight.delete(k);
                break;
            end
        end
    endtask

    // One clock: check the combinational grant, advance the model, check registered outputs.
    task automatic cycle();
        int           g;
        logic [N-1:0] er;
        logic [1:0]   id;
        int           d;
        #1;
        g = -1;
        if (!almfull) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (g < 0 && req_valid[c] && m_outst[c] < MAXO) g = c;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check("req_ready", req_ready, er);

        e_c0v = (g >= 0);
        if (g >= 0) begin
            e_addr  = req_addr[g*AW +: AW];
            e_mdata = {6'b0, 2'(g), req_tag[g*TW +: TW]};
            m_last  = g;
            inflight.push_back(e_mdata);
            e_issued[g]++;
        end
        if (almfull && req_valid != '0) e_stall++;

        id     = rx_mdata[9:8];
        e_rspv = '0;
        for (int i = 0; i < N; i++) begin
            d = ((g == i) ? 1 : 0) - ((rdvalid && id == i) ? 1 : 0);
            m_outst[i] += d;
            if (m_outst[i] < 0) begin
                m_outst[i] = 0;
                m_err      = 1'b1;
            end
        end
        if (rdvalid) begin
            if (int'(id) < N) begin
                e_rspv[id] = 1'b1;
                e_tag      = rx_mdata[7:0];
                e_data     = rx_data;
            end else begin
                m_err = 1'b1;
            end
        end

        @(posedge clk);
        @(negedge clk);
        check("c0tx_valid", c0tx_valid, e_c0v);
        check("c0tx_addr", c0tx_addr, e_addr);
        check("c0tx_mdata", c0tx_mdata, e_mdata);
        check("rsp_valid", rsp_valid, e_rspv);
        check("rsp_tag", rsp_tag, e_tag);
        check("rsp_data", rsp_data, e_data);
        for (int i = 0; i < N; i++) check("outst_cnt", outst_cnt[i*8 +: 8], m_outst[i]);
        check("err_underflow", dut.err_underflow_q, m_err);
`ifdef RD_ARB_STATS_EN
        for (int i = 0; i < N; i++) check("stat_issued", stat_issued[i*32 +: 32], e_issued[i]);
        check("stat_stall", stat_stall, e_stall);
`else
        check("stat_issued", stat_issued, 0);
        check("stat_stall", stat_stall, 0);
`endif
    endtask

    task automatic drain();
        req_valid = '0;
        almfull   = 1'b0;
        for (int b = 0; b < 64 && inflight.size() > 0; b++) begin
            drive_rsp(inflight[0]);
            cycle();
        end
        rdvalid = 1'b0;
        cycle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int obs_n [N];
        int r;
        int idx;
        logic [1:0] sid;

        rst = 1'b1;
        idle_inputs();
        req_addr = '0;
        req_tag  = '0;
        model_reset();
        #2;
        check("rst_ready", req_ready, 0);
        check("rst_c0v", c0tx_valid, 0);
        check("rst_addr", c0tx_addr, 0);
        check("rst_mdata", c0tx_mdata, 0);
        check("rst_rspv", rsp_valid, 0);
        check("rst_tag", rsp_tag, 0);
        check("rst_data", rsp_data, 0);
        check("rst_cnt", outst_cnt, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cycle();

        // First transfer from requester 0
        req_valid = 2'b01;
        set_req(0, 42'h100, 8'h05);
        cycle();
        check("t1_c0v", c0tx_valid, 1);
        check("t1_addr", c0tx_addr, 42'h100);
        check("t1_mdata", c0tx_mdata, 16'h0005);
        check("t1_cnt0", outst_cnt[7:0], 1);
        req_valid = '0;
        cycle();
        drain();

        // Both requesters continuously: strict alternation, starting after last winner 0
        for (int i = 0; i < N; i++) obs_n[i] = 0;
        req_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            set_req(0, 42'(16'h1000 + k), 8'(8'h10 + k));
            set_req(1, 42'(16'h2000 + k), 8'(8'h20 + k));
            cycle();
            check("alt_id", c0tx_mdata[9:8], (k + 1) % 2);
            if (c0tx_valid) obs_n[c0tx_mdata[9:8]]++;
        end
        check("alt_n0", obs_n[0], 4);
        check("alt_n1", obs_n[1], 4);

        // Requester 0 is at its limit; a response re-opens exactly one slot
        req_valid = 2'b01;
        repeat (3) begin
            cycle();
            check("lim_c0v", c0tx_valid, 0);
        end
        drive_rsp(16'h0002);
        cycle();
        check("lim_rspv", rsp_valid, 2'b01);
        check("lim_tag", rsp_tag, 8'h02);
        rdvalid = 1'b0;
        cycle();
        check("lim_regrant", {c0tx_valid, c0tx_mdata[9:8]}, 3'b100);
        cycle();
        check("lim_again", c0tx_valid, 0);
        drain();

        // almFull blocks all grants; release resumes in the same cycle
        req_valid = 2'b11;
        almfull   = 1'b1;
        repeat (5) cycle();
`ifdef RD_ARB_STATS_EN
        check("stall5", stat_stall, 5);
`else
        check("stall_off", stat_stall, 0);
`endif
        almfull = 1'b0;
        cycle();
        check("resume_c0v", c0tx_valid, 1);
        drain();

        // Same-cycle issue and response on requester 1
        req_valid = 2'b10;
        set_req(1, 42'h3c0, 8'h07);
        cycle();
        drive_rsp(16'h0107);
        cycle();
        check("same_cnt1", outst_cnt[15:8], 1);
        check("same_rspv", rsp_valid, 2'b10);
        check("same_tag", rsp_tag, 8'h07);
        rdvalid = 1'b0;
        drain();

        // Response carrying an out-of-range id
        drive_rsp(16'h0300);
        cycle();
        check("badid_rspv", rsp_valid, 0);
        check("badid_err", dut.err_underflow_q, 1);
        check("badid_cnt", outst_cnt, 0);
        rdvalid = 1'b0;

        // Asynchronous reset in the middle of traffic
        req_valid = 2'b11;
        repeat (3) cycle();
        #2;
        rst = 1'b1;
        #1;
        check("arst_ready", req_ready, 0);
        check("arst_c0v", c0tx_valid, 0);
        check("arst_cnt", outst_cnt, 0);
        check("arst_err", dut.err_underflow_q, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) set_req(i, {10'($urandom), 32'($urandom)}, 8'($urandom));
            almfull = ($urandom_range(0, 4) == 0);
            rdvalid = 1'b0;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                drive_rsp({6'b0, 2'($urandom_range(2, 3)), 8'($urandom)});
            end else if (r < 5) begin
                sid = 2'($urandom_range(0, N - 1));
                if (m_outst[sid] == 0) drive_rsp({6'b0, sid, 8'($urandom)});
            end else if (r < 60 && inflight.size() > 0) begin
                idx = $urandom_range(0, inflight.size() - 1);
                drive_rsp(inflight[idx]);
            end
            cycle();
        end
        idle_inputs();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ccip_rd_arbiter.md
# ccip_rd_arbiter

Shares the single CCI-P channel-0 read-request path between `NUM_REQ` internal read requesters (DMA source reader, descriptor fetcher, and others) inside the user AFU, ahead of the MPF read path. Arbitration is round-robin. The block stamps each request's Mdata with the requester index, routes read responses back to the owning requester, and enforces a per-requester outstanding-read limit. It also honours `c0TxAlmFull` so the AFU never overruns the FIU request queue.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, 2..4.
- `ADDR_W`, 42: cache-line address width.
- `TAG_W`, 8: requester-local tag width. Mdata = {zero pad, requester id (2 b), tag}, 16 bits total.
- `MAX_OUTST`, 64: per-requester outstanding-read limit, 1..255.

Ports:
- `Clk_400` in 1: CCI-P clock (pClk domain).
- `SoftReset` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_REQ: requester i has a read pending.
- `req_addr` in NUM_REQ*ADDR_W: line address; slice i belongs to requester i.
- `req_tag` in NUM_REQ*TAG_W: tag returned with the response.
- `req_ready` out NUM_REQ: one-hot grant; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `c0tx_valid` out 1: read request to the MPF/CCI-P c0Tx.
- `c0tx_addr` out ADDR_W.
- `c0tx_mdata` out 16.
- `c0TxAlmFull` in 1: FIU almost-full.
- `c0rx_rdValid` in 1: read response valid.
- `c0rx_mdata` in 16.
- `c0rx_data` in 512.
- `rsp_valid` out NUM_REQ: one-hot response strobe.
- `rsp_tag` out TAG_W.
- `rsp_data` out 512: shared across requesters.
- `outst_cnt` out NUM_REQ*8: live outstanding count per requester.
- `stat_issued` out NUM_REQ*32: issued-read counters (see Configuration).
- `stat_stall` out 32: count of almFull-blocked cycles (see Configuration).

## Operation
- Eligibility: `elig[i] = req_valid[i] & (outst[i] < MAX_OUTST)`.
- Grant:
  - No grant is issued while `c0TxAlmFull` = 1.
  - Otherwise the grant goes to the first eligible index after `last_grant`, searching upward with wrap.
  - `req_ready` is combinational from the current `elig`, `c0TxAlmFull` and `last_grant`; it is one-hot or zero.
- Issue: on a transfer from requester i:
  - `c0tx_addr` ← `req_addr[i]`.
  - `c0tx_mdata` ← {6'b0, i[1:0], `req_tag[i]`}.
  - `c0tx_valid` ← 1 for exactly one cycle.
  - `last_grant` ← i.
  - `outst[i]` increments.
- Response: on `c0rx_rdValid`:
  - id = `c0rx_mdata[9:8]`.
  - Next cycle, `rsp_valid[id]` = 1, `rsp_tag` = `c0rx_mdata[7:0]`, `rsp_data` = `c0rx_data`.
  - `outst[id]` decrements.
- Simultaneous issue and response for the same requester: the count is unchanged.
- Decrementing a zero count (spurious response): the count stays 0 and sticky `err_underflow` is set internally, visible in simulation. The response is still forwarded.
- An id ≥ `NUM_REQ` in a response: the response is dropped and `err_underflow` is set.
- Requesters have no backpressure on responses; each requester must accept a response every cycle.

## Timing
- Request path: 1-cycle latency, from the transfer edge to `c0tx_valid` registered high.
- Response path: 1-cycle latency, from `c0rx_rdValid` to `rsp_valid`.
- Throughput: one request per cycle sustained while not almFull. A single eligible requester is granted every cycle.
- `c0TxAlmFull` is sampled in the same cycle as the grant. A request already registered still issues in the following cycle; this is within the CCI-P almFull slack.
- Reset values: `req_ready` = 0, `c0tx_valid` = 0, `c0tx_addr` = 0, `c0tx_mdata` = 0, `rsp_valid` = 0, `rsp_tag` = 0, `rsp_data` = 0, all counts 0, `last_grant` = `NUM_REQ`-1 (so requester 0 wins first), stats 0.
- Reset mid-operation: all state clears immediately (asynchronous). In-flight responses arriving after reset release are treated as spurious.

## Configuration
- `RD_ARB_STATS_EN`
  - Defined: `stat_issued[i]` increments on each issue by requester i; `stat_stall` increments on every cycle with `c0TxAlmFull` = 1 and any `req_valid` high. Both are 32-bit and wrap.
  - Undefined: both outputs are tied to 0 and no counter flops exist.

## Test plan
- Reset then idle: all outputs 0. Assert `req_valid[0]` with addr 0x100 and tag 0x05 → next cycle `c0tx_valid` = 1, addr 0x100, mdata 0x0005, `outst_cnt[0]` = 1.
- Both requesters valid continuously for 8 cycles → grants alternate 0,1,0,1…; 4 issues each; mdata bits [9:8] alternate.
- `MAX_OUTST` = 4, requester 0 valid with no responses → exactly 4 issues, then `req_ready[0]` = 0. A response with mdata 0x0002 → `rsp_valid[0]` and `rsp_tag` = 0x02 next cycle, and one more grant follows.
- `c0TxAlmFull` = 1 for 5 cycles with requests pending → no `req_ready`. With the macro defined, `stat_stall` = 5. Deasserting almFull resumes grants in that cycle.
- Requester 1 issues and receives a response (mdata 0x0107) in the same cycle → `outst_cnt[1]` is unchanged, and `rsp_valid[1]` with tag 0x07 follows.
- Response mdata 0x0300 with `NUM_REQ` = 2 → no `rsp_valid`, `err_underflow` = 1, counts unchanged.
